// File: rtl/alu_pkg.sv
// Shared constants for the ALU/UART sequencing stage: opcodes, FSM encoding,
// error byte and the opcode legality helper.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

    typedef enum logic [2:0] {
        ST_WAIT_A  = S_WAIT_A,
        ST_WAIT_B  = S_WAIT_B,
        ST_WAIT_OP = S_WAIT_OP,
        ST_LOAD    = S_LOAD,
        ST_WAIT_TX = S_WAIT_TX
    } state_t;

    localparam logic [7:0] ERR_BYTE = 8'hFF;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_uart_intf.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU, and
// hands the result to the transmitter. Optional opcode check: ALU_INTF_OPCHECK_EN.
module alu_uart_intf
    import alu_pkg::*;
#(
    parameter int DBIT   = 8,
    parameter int OPCODE = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DBIT-1:0]   rx_data,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   alu_result,
    input  logic              tx_done_tick,
    output logic [DBIT-1:0]   A,
    output logic [DBIT-1:0]   B,
    output logic [OPCODE-1:0] OP,
    output logic [DBIT-1:0]   tx_data,
    output logic              tx_start,
`ifdef ALU_INTF_OPCHECK_EN
    output logic              err_op,
`endif
    output logic              busy
);

    state_t state_r;
    state_t state_next_s;
    logic   ld_a_s;
    logic   ld_b_s;
    logic   ld_op_s;
    logic   ld_tx_s;
    logic   tx_ack_s;

    // Next-state and load-enable decode; bytes arriving in LOAD/WAIT_TX are dropped.
    always_comb begin
        state_next_s = state_r;
        ld_a_s       = 1'b0;
        ld_b_s       = 1'b0;
        ld_op_s      = 1'b0;
        ld_tx_s      = 1'b0;
        tx_ack_s     = 1'b0;
        case (state_r)
            ST_WAIT_A: begin
                if (rx_done_tick) begin
                    ld_a_s       = 1'b1;
                    state_next_s = ST_WAIT_B;
                end else begin
                    state_next_s = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (rx_done_tick) begin
                    ld_b_s       = 1'b1;
                    state_next_s = ST_WAIT_OP;
                end else begin
                    state_next_s = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (rx_done_tick) begin
                    ld_op_s      = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_WAIT_OP;
                end
            end
            ST_LOAD: begin
                ld_tx_s      = 1'b1;
                state_next_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done_tick) begin
                    tx_ack_s     = 1'b1;
                    state_next_s = ST_WAIT_A;
                end else begin
                    state_next_s = ST_WAIT_TX;
                end
            end
            default: begin
                state_next_s = ST_WAIT_A;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial operand set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_WAIT_A;
            A        <= {DBIT{1'b0}};
            B        <= {DBIT{1'b0}};
            OP       <= {OPCODE{1'b0}};
            tx_data  <= {DBIT{1'b0}};
            tx_start <= 1'b0;
            busy     <= 1'b0;
`ifdef ALU_INTF_OPCHECK_EN
            err_op   <= 1'b0;
`endif
        end else begin
            state_r  <= state_next_s;
            tx_start <= ld_tx_s;
            if (ld_a_s)  A  <= rx_data;
            if (ld_b_s)  B  <= rx_data;
            if (ld_op_s) OP <= rx_data[OPCODE-1:0];
            if (ld_tx_s) begin
                busy <= 1'b1;
`ifdef ALU_INTF_OPCHECK_EN
                tx_data <= op_is_legal(OP) ? alu_result : {DBIT{1'b1}};
                err_op  <= ~op_is_legal(OP);
`else
                tx_data <= alu_result;
`endif
            end else if (tx_ack_s) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_intf.sv
// Self-checking bench for alu_uart_intf: directed test-plan sequences plus
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_alu_uart_intf;

    localparam int DBIT   = 8;
    localparam int OPCODE = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [DBIT-1:0]   rx_data;
    logic              rx_done_tick;
    logic [DBIT-1:0]   alu_result;
    logic              tx_done_tick;
    logic [DBIT-1:0]   A;
    logic [DBIT-1:0]   B;
    logic [OPCODE-1:0] OP;
    logic [DBIT-1:0]   tx_data;
    logic              tx_start;
    logic              busy;
`ifdef ALU_INTF_OPCHECK_EN
    logic              err_op;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    alu_uart_intf #(.DBIT(DBIT), .OPCODE(OPCODE)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .A            (A),
        .B            (B),
        .OP           (OP),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
`ifdef ALU_INTF_OPCHECK_EN
        .err_op       (err_op),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    endfunction

    assign alu_result = alu_fn(A, B, OP);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: byte counter, pending result, transmit-in-flight flag.
    int         m_cnt;
    bit         m_load;
    bit         m_tx;
    logic [7:0] m_a, m_b, m_txd;
    logic [5:0] m_op;
    logic       m_start, m_busy, m_err;

    // Model update on each rising edge from the inputs applied in that cycle.
    always @(posedge clk) begin
        m_start <= 1'b0;
        if (reset) begin
            m_cnt <= 0; m_load <= 1'b0; m_tx <= 1'b0;
            m_a <= 8'h00; m_b <= 8'h00; m_op <= 6'h00; m_txd <= 8'h00;
            m_busy <= 1'b0; m_err <= 1'b0;
        end else if (m_load) begin
`ifdef ALU_INTF_OPCHECK_EN
            m_txd <= legal(m_op) ? alu_fn(m_a, m_b, m_op) : 8'hFF;
            m_err <= !legal(m_op);
`else
            m_txd <= alu_fn(m_a, m_b, m_op);
`endif
            m_start <= 1'b1;
            m_busy  <= 1'b1;
            m_load  <= 1'b0;
            m_tx    <= 1'b1;
        end else if (m_tx) begin
            if (tx_done_tick) begin
                m_busy <= 1'b0;
                m_tx   <= 1'b0;
                m_cnt  <= 0;
            end
        end else if (rx_done_tick) begin
            if (m_cnt == 0) begin
                m_a <= rx_data; m_cnt <= 1;
            end else if (m_cnt == 1) begin
                m_b <= rx_data; m_cnt <= 2;
            end else begin
                m_op <= rx_data[5:0]; m_cnt <= 0; m_load <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("OP", OP, m_op);
            chk("tx_data", tx_data, m_txd);
            chk("tx_start", tx_start, m_start);
            chk("busy", busy, m_busy);
`ifdef ALU_INTF_OPCHECK_EN
            chk("err_op", err_op, m_err);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic pulse_tx();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
    endtask

    // Sends a triple and pins latency and result with literal expectations; ends in WAIT_TX.
    task automatic triple(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp_tx,
                          input logic [5:0] exp_op);
        send(a);
        send(b);
        send(op);
        chk({nm, "_start_k1"}, tx_start, 1'b0);
        step();
        chk({nm, "_start_k2"}, tx_start, 1'b1);
        chk({nm, "_txd"}, tx_data, exp_tx);
        chk({nm, "_A"}, A, a);
        chk({nm, "_B"}, B, b);
        chk({nm, "_OP"}, OP, exp_op);
        chk({nm, "_busy"}, busy, 1'b1);
        step();
        chk({nm, "_start_k3"}, tx_start, 1'b0);
        chk({nm, "_txd_hold"}, tx_data, exp_tx);
    endtask

    initial begin
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_A", A, 8'h00);
        chk("rst_OP", OP, 6'h00);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step();

        triple("add", 8'h05, 8'h03, 8'h20, 8'h08, 6'h20);
        repeat (3) step();
        chk("add_busy_hold", busy, 1'b1);
        pulse_tx();
        chk("add_busy_clr", busy, 1'b0);

        triple("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 6'h22);
        pulse_tx();
        triple("xor", 8'hF0, 8'h3C, 8'h26, 8'hCC, 6'h26);
        pulse_tx();
        triple("and_mask", 8'h0F, 8'h3C, 8'hE4, 8'h0C, 6'h24);

        send(8'h77);
        chk("drop_A", A, 8'h0F);
        rx_data      = 8'h55;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        chk("b2b_busy", busy, 1'b0);
        chk("b2b_A", A, 8'h0F);
        send(8'h11);
        chk("next_A", A, 8'h11);
        send(8'h22);
        chk("next_B", B, 8'h22);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_A", A, 8'h00);
        chk("mid_rst_B", B, 8'h00);
        chk("mid_rst_txd", tx_data, 8'h00);
        triple("after_rst", 8'h01, 8'h01, 8'h20, 8'h02, 6'h20);
        pulse_tx();

`ifdef ALU_INTF_OPCHECK_EN
        triple("illegal", 8'h00, 8'h00, 8'h3F, 8'hFF, 6'h3F);
        chk("illegal_err", err_op, 1'b1);
        pulse_tx();
        triple("legal", 8'h02, 8'h02, 8'h20, 8'h04, 6'h20);
        chk("legal_err", err_op, 1'b0);
        pulse_tx();
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] lops [8];
            lops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
            rx_done_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0)
                rx_data = {2'($urandom), lops[$urandom_range(0, 7)]};
            else
                rx_data = 8'($urandom);
            tx_done_tick = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            step();
        end
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        reset        = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
